if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and the decode stage. Buffers {pc, pc_plus4, instr}
//  tuples from fetch, presents the oldest to decode with a valid/ready handshake, and raises
//  stall_f to fetch when full. A flush (taken branch/jump resolved in execute) empties it.
// PARAMETERS
//  DATA_WIDTH     32  instruction width
//  ADDRESS_WIDTH  32  pc / pc_plus4 width
//  DEPTH          4   entries; power of two, >= 2
// PORTS
//  clk           in   1              rising-edge clock
//  rst           in   1              asynchronous, active-low reset
//  push_valid    in   1              fetch presents a valid instruction this cycle
//  push_pc       in   ADDRESS_WIDTH  pc of pushed instruction
//  push_pc_plus4 in   ADDRESS_WIDTH  pc+4 of pushed instruction
//  push_instr    in   DATA_WIDTH     pushed instruction word
//  flush         in   1              redirect from execute (pc_src_e != 0); discard all entries
//  pop_ready     in   1              decode accepts head entry this cycle
//  out_valid     out  1              head entry valid
//  out_pc        out  ADDRESS_WIDTH  head pc
//  out_pc_plus4  out  ADDRESS_WIDTH  head pc+4
//  out_instr     out  DATA_WIDTH     head instruction; NOP when !out_valid
//  stall_f       out  1              queue full; fetch must hold pc
//  count         out  $clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, out_valid=0, stall_f=0, out_pc=0,
//    out_pc_plus4=0, out_instr=NOP (32'h0000_0013). Storage contents need not be cleared.
//  - push = push_valid & ~stall_f & ~flush; pop = out_valid & pop_ready & ~flush.
//  - push writes entry[wr_ptr], wr_ptr++; pop advances rd_ptr++. Pointers are $clog2(DEPTH)
//    bits and wrap modulo DEPTH.
//  - count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//  - stall_f = (count == DEPTH), derived from registered count; push while full is dropped,
//    even if a pop occurs the same cycle (no pass-through when full).
//  - out_* read combinationally from entry[rd_ptr]; out_valid = (count != 0). When empty,
//    out_instr=NOP and out_pc/out_pc_plus4=0. No bypass: a push at edge N is visible at
//    out_* after edge N (1-cycle latency).
//  - Simultaneous push & pop on empty: impossible (pop needs out_valid); push proceeds.
//  - flush: at next edge count=0, rd_ptr=wr_ptr (both reset to 0); flush has priority over
//    push and pop in the same cycle; out_valid=0 in the following cycle.
//  - Reset asserted mid-operation: all state returns to reset values immediately.
//  - No state machine beyond pointers/count; the head entry is held stable while
//    out_valid & ~pop_ready.
// STRUCTURE
//  - Shared package: NOP_INSTR = 32'h0000_0013 constant; entry field widths.
//  - One sub-module: queue_storage (DEPTH x (2*ADDRESS_WIDTH+DATA_WIDTH) register array,
//    one write port, one async read port, no reset). Pointer/count control stays here.
// TESTING
//  - Reset: drive rst=0 mid-run with 3 entries -> out_valid=0, count=0, stall_f=0,
//    out_instr=32'h13 asynchronously.
//  - Fill: push pc=0,4,8,12 with pop_ready=0 -> count=4, stall_f=1; 5th push (pc=16)
//    dropped; head remains pc=0.
//  - Drain order: pop_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles, then
//    out_valid=0.
//  - Concurrent push/pop at count=2 for 10 cycles -> count stays 2, in-order data,
//    pointers wrap cleanly past DEPTH.
//  - Full + pop + push same cycle -> pop taken, push dropped, count=3, stall_f=0 next cycle.
//  - Flush with 3 entries plus simultaneous push and pop -> next cycle count=0,
//    out_valid=0; the next push pc=0x40 appears as head one cycle later.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue.
//  NOP_INSTR         : instruction presented to decode while the queue is empty (addi x0,x0,0)
//  DEF_DATA_WIDTH    : default instruction width
//  DEF_ADDRESS_WIDTH : default pc / pc_plus4 width
package if_id_queue_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int unsigned DEF_DATA_WIDTH    = 32;
   localparam int unsigned DEF_ADDRESS_WIDTH = 32;

   // Width of one stored {pc, pc_plus4, instr} tuple.
   function automatic int unsigned entry_width(int unsigned aw, int unsigned dw);
      return 2 * aw + dw;
   endfunction

endpackage

// File: rtl/if_id_queue_storage.sv
// Register array holding the queued {pc, pc_plus4, instr} tuples.
//  clk   : rising-edge clock
//  we    : write enable
//  waddr : write index
//  wdata : packed entry to write
//  raddr : read index (asynchronous read)
//  rdata : packed entry at raddr
// Contents are not reset; validity is tracked by the controller's count.
module if_id_queue_storage
   import if_id_queue_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned WIDTH   = entry_width(DEF_ADDRESS_WIDTH, DEF_DATA_WIDTH),
   parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode.
//  clk, rst                     : clock, asynchronous active-low reset
//  push_valid/push_pc/
//  push_pc_plus4/push_instr     : entry offered by fetch
//  flush                        : redirect from execute; discards every entry
//  pop_ready                    : decode accepts the head entry
//  out_valid/out_pc/
//  out_pc_plus4/out_instr       : head entry (NOP and zero pcs when empty)
//  stall_f                      : queue full, fetch must hold its pc
//  count                        : number of occupied entries
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_valid,
   input  logic [ADDRESS_WIDTH-1:0]   push_pc,
   input  logic [ADDRESS_WIDTH-1:0]   push_pc_plus4,
   input  logic [DATA_WIDTH-1:0]      push_instr,
   input  logic                       flush,
   input  logic                       pop_ready,
   output logic                       out_valid,
   output logic [ADDRESS_WIDTH-1:0]   out_pc,
   output logic [ADDRESS_WIDTH-1:0]   out_pc_plus4,
   output logic [DATA_WIDTH-1:0]      out_instr,
   output logic                       stall_f,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned ENTRY_W = entry_width(ADDRESS_WIDTH, DATA_WIDTH);

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push, pop;
   logic [ENTRY_W-1:0] head;

   assign out_valid = (count_q != '0);
   assign stall_f   = (count_q == CNT_W'(DEPTH));
   assign count     = count_q;

   // Full blocks the push even when a pop happens the same cycle.
   assign push = push_valid & ~stall_f & ~flush;
   assign pop  = out_valid & pop_ready & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   if_id_queue_storage #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .PTR_W (PTR_W)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata ({push_pc, push_pc_plus4, push_instr}),
      .raddr (rd_ptr_q),
      .rdata (head)
   );

   always_comb begin
      out_pc       = '0;
      out_pc_plus4 = '0;
      out_instr    = DATA_WIDTH'(NOP_INSTR);
      if (out_valid) begin
         out_pc       = head[ENTRY_W-1 -: ADDRESS_WIDTH];
         out_pc_plus4 = head[DATA_WIDTH +: ADDRESS_WIDTH];
         out_instr    = head[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          DEP = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        push_valid = 1'b0;
   logic [31:0] push_pc = '0;
   logic [31:0] push_pc_plus4 = '0;
   logic [31:0] push_instr = '0;
   logic        flush = 1'b0;
   logic        pop_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [31:0] out_instr;
   logic        stall_f;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   if_id_queue #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (32),
      .DEPTH         (DEP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .push_valid    (push_valid),
      .push_pc       (push_pc),
      .push_pc_plus4 (push_pc_plus4),
      .push_instr    (push_instr),
      .flush         (flush),
      .pop_ready     (pop_ready),
      .out_valid     (out_valid),
      .out_pc        (out_pc),
      .out_pc_plus4  (out_pc_plus4),
      .out_instr     (out_instr),
      .stall_f       (stall_f),
      .count         (count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
   } ent_t;

   ent_t mq[$];

   typedef struct {
      logic        pv;
      logic [31:0] pc;
      logic        fl;
      logic        pr;
      int          cnt;
      logic        vld;
      logic [31:0] hpc;
      logic        stl;
   } vec_t;

   vec_t tbl[19];

   function automatic logic [31:0] instr_of(logic [31:0] pc);
      return {pc[15:0], 16'h0093} ^ 32'h1234_0000;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic pv, logic [31:0] pc, logic fl, logic pr);
      push_valid    = pv;
      push_pc       = pc;
      push_pc_plus4 = pc + 32'd4;
      push_instr    = instr_of(pc);
      flush         = fl;
      pop_ready     = pr;
   endtask

   // Queue-level reference: flush empties, otherwise pop head if any and push if not full.
   task automatic model_edge();
      bit do_push, do_pop;
      if (flush) begin
         mq.delete();
      end else begin
         do_push = push_valid && (mq.size() < DEP);
         do_pop  = pop_ready && (mq.size() > 0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{pc: push_pc, pc4: push_pc_plus4, instr: push_instr});
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(string tag, int cnt, logic vld, logic [31:0] hpc, logic stl);
      check({tag, ".count"}, 64'(count), 64'(cnt));
      check({tag, ".valid"}, 64'(out_valid), 64'(vld));
      check({tag, ".pc"}, 64'(out_pc), vld ? 64'(hpc) : 64'(0));
      check({tag, ".pc4"}, 64'(out_pc_plus4), vld ? 64'(hpc + 32'd4) : 64'(0));
      check({tag, ".instr"}, 64'(out_instr), vld ? 64'(instr_of(hpc)) : 64'(NOP));
      check({tag, ".stall"}, 64'(stall_f), 64'(stl));
   endtask

   task automatic check_model(string tag);
      int n;
      n = mq.size();
      check({tag, ".count"}, 64'(count), 64'(n));
      check({tag, ".valid"}, 64'(out_valid), 64'(n != 0));
      check({tag, ".stall"}, 64'(stall_f), 64'(n == DEP));
      check({tag, ".pc"}, 64'(out_pc), (n != 0) ? 64'(mq[0].pc) : 64'(0));
      check({tag, ".pc4"}, 64'(out_pc_plus4), (n != 0) ? 64'(mq[0].pc4) : 64'(0));
      check({tag, ".instr"}, 64'(out_instr), (n != 0) ? 64'(mq[0].instr) : 64'(NOP));
   endtask

   initial begin
      // Fill/drop, drain order, refill, full+pop+push, hold, flush with push+pop, post-flush push.
      tbl[0]  = '{1, 32'h00, 0, 0, 1, 1, 32'h00, 0};
      tbl[1]  = '{1, 32'h04, 0, 0, 2, 1, 32'h00, 0};
      tbl[2]  = '{1, 32'h08, 0, 0, 3, 1, 32'h00, 0};
      tbl[3]  = '{1, 32'h0c, 0, 0, 4, 1, 32'h00, 1};
      tbl[4]  = '{1, 32'h10, 0, 0, 4, 1, 32'h00, 1};
      tbl[5]  = '{0, 32'h00, 0, 1, 3, 1, 32'h04, 0};
      tbl[6]  = '{0, 32'h00, 0, 1, 2, 1, 32'h08, 0};
      tbl[7]  = '{0, 32'h00, 0, 1, 1, 1, 32'h0c, 0};
      tbl[8]  = '{0, 32'h00, 0, 1, 0, 0, 32'h00, 0};
      tbl[9]  = '{1, 32'h20, 0, 0, 1, 1, 32'h20, 0};
      tbl[10] = '{1, 32'h24, 0, 0, 2, 1, 32'h20, 0};
      tbl[11] = '{1, 32'h28, 0, 0, 3, 1, 32'h20, 0};
      tbl[12] = '{1, 32'h2c, 0, 0, 4, 1, 32'h20, 1};
      tbl[13] = '{1, 32'h30, 0, 1, 3, 1, 32'h24, 0};
      tbl[14] = '{0, 32'h00, 0, 0, 3, 1, 32'h24, 0};
      tbl[15] = '{1, 32'h34, 1, 1, 0, 0, 32'h00, 0};
      tbl[16] = '{1, 32'h40, 0, 0, 1, 1, 32'h40, 0};
      tbl[17] = '{0, 32'h00, 0, 0, 1, 1, 32'h40, 0};
      tbl[18] = '{0, 32'h00, 0, 1, 0, 0, 32'h00, 0};

      // Reset state.
      drive(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_head("reset", 0, 0, 0, 0);
      rst = 1'b1;
      mq.delete();
      @(posedge clk);
      #1;
      check_head("reset_rel", 0, 0, 0, 0);

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].pv, tbl[i].pc, tbl[i].fl, tbl[i].pr);
         cycle();
         check_head($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].hpc, tbl[i].stl);
      end

      // Steady push+pop at count 2; pointers wrap several times.
      drive(1, 32'h100, 0, 0);
      cycle();
      drive(1, 32'h104, 0, 0);
      cycle();
      check_head("conc_pre", 2, 1, 32'h100, 0);
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h108 + 32'(4 * i), 0, 1);
         cycle();
         check_head($sformatf("conc%0d", i), 2, 1, 32'h104 + 32'(4 * i), 0);
      end
      drive(0, 0, 0, 1);
      cycle();
      check_head("conc_d0", 1, 1, 32'h12c, 0);
      cycle();
      check_head("conc_d1", 0, 0, 0, 0);

      // Asynchronous reset mid-operation with three entries.
      drive(1, 32'h200, 0, 0);
      cycle();
      drive(1, 32'h204, 0, 0);
      cycle();
      drive(1, 32'h208, 0, 0);
      cycle();
      check_head("pre_rst", 3, 1, 32'h200, 0);
      drive(0, 0, 0, 0);
      #2;
      rst = 1'b0;
      mq.delete();
      #1;
      check_head("async_rst", 0, 0, 0, 0);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_head("post_rst", 0, 0, 0, 0);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 5);
         cycle();
         check_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
